// File: rtl/cpu_pkg.sv
// Shared MIPS pipeline definitions: instruction classes, encodings, Tuse/Tnew
// values, forwarding selects and the shadow-stage record.
package cpu_pkg;

    localparam int REG_IDX_W = 5;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_CAL_R, CLS_CAL_I, CLS_LOAD, CLS_STORE, CLS_B, CLS_J,
        CLS_JAL, CLS_JR, CLS_JALR, CLS_MD, CLS_MT, CLS_MF
    } instr_cls_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_SLTIU   = 6'h0b;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2a;
    localparam logic [5:0] F_SLTU  = 6'h2b;

    // Tnew never exceeds 2, so a Tuse of 3 can never trigger a stall.
    typedef logic [1:0] tval_t;
    localparam tval_t T_0      = 2'd0;
    localparam tval_t T_1      = 2'd1;
    localparam tval_t T_2      = 2'd2;
    localparam tval_t TUSE_INF = 2'd3;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b11;

    typedef struct packed {
        instr_cls_e cls;
        reg_idx_t   rs;
        reg_idx_t   rt;
        reg_idx_t   dest;
        tval_t      tnew;
        logic       md_div;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{
        cls: CLS_NOP, rs: '0, rt: '0, dest: '0, tnew: T_0, md_div: 1'b0
    };

    function automatic tval_t tnew_dec(input tval_t t);
        return (t == T_0) ? T_0 : t - T_1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side view of the hazard controller: instruction/hold in,
// stall, forwarding selects and MD-busy out.
interface hazard_ctrl_if;
    logic [31:0] instr_d;
    logic        hold;
    logic        stall;
    logic [1:0]  fwd_rs_d;
    logic [1:0]  fwd_rt_d;
    logic [1:0]  fwd_rs_e;
    logic [1:0]  fwd_rt_e;
    logic        fwd_rt_m;
    logic        md_busy;

    modport master (
        output instr_d, hold,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );

    modport slave (
        input  instr_d, hold,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );
endinterface

// File: rtl/instr_class.sv
// Combinational MIPS instruction classifier: class, source/destination
// registers, Tuse per source and Tnew on entry to E.
module instr_class
    import cpu_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [31:0]      instr,
    output instr_cls_e       cls,
    output logic [REG_W-1:0] rs,
    output logic [REG_W-1:0] rt,
    output logic [REG_W-1:0] dest,
    output tval_t            tuse_rs,
    output tval_t            tuse_rt,
    output tval_t            tnew,
    output logic             md_div
);

    logic [5:0]       op;
    logic [5:0]       funct;
    logic [REG_W-1:0] rd;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rs    = REG_W'(instr[25:21]);
    assign rt    = REG_W'(instr[20:16]);
    assign rd    = REG_W'(instr[15:11]);

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        cls    = CLS_NOP;
        md_div = 1'b0;
        if (instr != 32'd0) begin
            case (op)
                OP_SPECIAL: begin
                    case (funct)
                        F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
                        F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
                        F_XOR, F_NOR, F_SLT, F_SLTU: cls = CLS_CAL_R;
                        F_JR:                        cls = CLS_JR;
                        F_JALR:                      cls = CLS_JALR;
                        F_MFHI, F_MFLO:              cls = CLS_MF;
                        F_MTHI, F_MTLO:              cls = CLS_MT;
                        F_MULT, F_MULTU:             cls = CLS_MD;
                        F_DIV, F_DIVU: begin
                            cls    = CLS_MD;
                            md_div = 1'b1;
                        end
                        default:                     cls = CLS_NOP;
                    endcase
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                OP_ANDI, OP_ORI, OP_XORI, OP_LUI:     cls = CLS_CAL_I;
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:  cls = CLS_LOAD;
                OP_SB, OP_SH, OP_SW:                  cls = CLS_STORE;
                OP_BEQ, OP_BNE:                       cls = CLS_B;
                OP_J:                                 cls = CLS_J;
                OP_JAL:                               cls = CLS_JAL;
                default:                              cls = CLS_NOP;
            endcase
        end
    end

    always_comb begin
        dest    = '0;
        tuse_rs = TUSE_INF;
        tuse_rt = TUSE_INF;
        tnew    = T_0;
        case (cls)
            CLS_CAL_R: begin dest = rd; tuse_rs = T_1; tuse_rt = T_1; tnew = T_1; end
            CLS_CAL_I: begin dest = rt; tuse_rs = T_1; tnew = T_1; end
            CLS_LOAD:  begin dest = rt; tuse_rs = T_1; tnew = T_2; end
            CLS_STORE: begin tuse_rs = T_1; tuse_rt = T_2; end
            CLS_B:     begin tuse_rs = T_0; tuse_rt = T_0; end
            CLS_JAL:   begin dest = REG_W'(31); end
            CLS_JR:    begin tuse_rs = T_0; end
            CLS_JALR:  begin dest = rd; tuse_rs = T_0; end
            CLS_MD:    begin tuse_rs = T_1; tuse_rt = T_1; end
            CLS_MT:    begin tuse_rs = T_1; end
            CLS_MF:    begin dest = rd; tnew = T_1; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: shadow E/M/W stages, MD busy counter, D-stage stall
// and D/E/M forwarding selects.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);

    instr_cls_e       dec_cls;
    logic [REG_W-1:0] dec_rs, dec_rt, dec_dest;
    tval_t            dec_tuse_rs, dec_tuse_rt, dec_tnew;
    logic             dec_md_div;

    instr_class #(.REG_W(REG_W)) u_instr_class (
        .instr   (hz.instr_d),
        .cls     (dec_cls),
        .rs      (dec_rs),
        .rt      (dec_rt),
        .dest    (dec_dest),
        .tuse_rs (dec_tuse_rs),
        .tuse_rt (dec_tuse_rt),
        .tnew    (dec_tnew),
        .md_div  (dec_md_div)
    );

    stage_t            e_q, e_d, m_q, m_d, w_q, w_d;
    logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;
    reg_idx_t          src_rs, src_rt;
    logic              data_stall, md_stall, stall, md_busy;

    assign src_rs = reg_idx_t'(dec_rs);
    assign src_rt = reg_idx_t'(dec_rt);

    function automatic logic needs_stall(input reg_idx_t src, input tval_t tuse,
                                         input stage_t s);
        return (src != '0) && (s.dest == src) && (s.tnew > tuse);
    endfunction

    // A stage can supply a value only once its result exists (tnew == 0).
    function automatic logic fwd_hit(input reg_idx_t src, input stage_t s);
        return (src != '0) && (s.dest == src) && (s.tnew == T_0);
    endfunction

    assign data_stall = needs_stall(src_rs, dec_tuse_rs, e_q) |
                        needs_stall(src_rs, dec_tuse_rs, m_q) |
                        needs_stall(src_rt, dec_tuse_rt, e_q) |
                        needs_stall(src_rt, dec_tuse_rt, m_q);
    assign md_busy    = (md_cnt_q != '0) || (e_q.cls == CLS_MD);
    assign md_stall   = md_busy && (dec_cls inside {CLS_MD, CLS_MT, CLS_MF});
    assign stall      = data_stall | md_stall;

    assign hz.stall   = stall;
    assign hz.md_busy = md_busy;

    always_comb begin
        hz.fwd_rs_d = FWD_RF;
        hz.fwd_rt_d = FWD_RF;
        hz.fwd_rs_e = FWD_RF;
        hz.fwd_rt_e = FWD_RF;
        hz.fwd_rt_m = 1'b0;

        if      (fwd_hit(src_rs, e_q)) hz.fwd_rs_d = FWD_E;
        else if (fwd_hit(src_rs, m_q)) hz.fwd_rs_d = FWD_M;
        else if (fwd_hit(src_rs, w_q)) hz.fwd_rs_d = FWD_W;

        if      (fwd_hit(src_rt, e_q)) hz.fwd_rt_d = FWD_E;
        else if (fwd_hit(src_rt, m_q)) hz.fwd_rt_d = FWD_M;
        else if (fwd_hit(src_rt, w_q)) hz.fwd_rt_d = FWD_W;

        if      (fwd_hit(e_q.rs, m_q)) hz.fwd_rs_e = FWD_M;
        else if (fwd_hit(e_q.rs, w_q)) hz.fwd_rs_e = FWD_W;

        if      (fwd_hit(e_q.rt, m_q)) hz.fwd_rt_e = FWD_M;
        else if (fwd_hit(e_q.rt, w_q)) hz.fwd_rt_e = FWD_W;

        hz.fwd_rt_m = fwd_hit(m_q.rt, w_q);
    end

    always_comb begin
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;
        if (!hz.hold) begin
            w_d      = m_q;
            w_d.tnew = tnew_dec(m_q.tnew);
            m_d      = e_q;
            m_d.tnew = tnew_dec(e_q.tnew);
            if (stall) begin
                e_d = STAGE_BUBBLE;
            end else begin
                e_d = '{cls: dec_cls, rs: src_rs, rt: src_rt,
                        dest: reg_idx_t'(dec_dest), tnew: dec_tnew,
                        md_div: dec_md_div};
            end
        end
    end

    // The MD unit keeps running through hold; its count starts from the
    // op's last cycle in E, which md_busy already covers via class_E.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (e_q.cls == CLS_MD) begin
            md_cnt_d = e_q.md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q      <= STAGE_BUBBLE;
            m_q      <= STAGE_BUBBLE;
            w_q      <= STAGE_BUBBLE;
            md_cnt_q <= '0;
        end else begin
            e_q      <= e_d;
            m_q      <= m_d;
            w_q      <= w_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: expected output vectors are
// queued as each D-stage instruction is driven and checked mid-cycle.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.REG_W(5), .MULT_LAT(5), .DIV_LAT(10)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [10:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    localparam logic [31:0] NOP = 32'd0;

    function automatic logic [31:0] r_op(input logic [5:0] funct, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy}
    function automatic logic [10:0] ev(input logic st, input logic [1:0] rsd,
                                       input logic [1:0] rtd, input logic [1:0] rse,
                                       input logic [1:0] rte, input logic rtm,
                                       input logic busy);
        return {st, rsd, rtd, rse, rte, rtm, busy};
    endfunction

    task automatic expect_out(input string tag, input logic [10:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [10:0] obs;
        obs = {hz.stall, hz.fwd_rs_d, hz.fwd_rt_d, hz.fwd_rs_e, hz.fwd_rt_e,
               hz.fwd_rt_m, hz.md_busy};
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: got %b want <entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: got %b want %b", e.tag, obs, e.val);
            end
        end
    endtask

    // One D-stage cycle: drive after the edge, check on the falling edge.
    task automatic cycle(input logic [31:0] instr, input logic hold_i,
                         input logic [10:0] exp_v, input string tag);
        hz.instr_d = instr;
        hz.hold    = hold_i;
        expect_out(tag, exp_v);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] lw1, addu2, addu3, beq3, jal0, jr31, lw7, sw7;
        logic [31:0] addu0, subu4, mult12, mfhi3, div56;
        lw1    = i_op(6'h23, 5'd0, 5'd1, 16'd0);
        addu2  = r_op(6'h21, 5'd1, 5'd1, 5'd2);
        addu3  = r_op(6'h21, 5'd4, 5'd5, 5'd3);
        beq3   = i_op(6'h04, 5'd3, 5'd0, 16'd4);
        jal0   = {6'h03, 26'd0};
        jr31   = r_op(6'h08, 5'd31, 5'd0, 5'd0);
        lw7    = i_op(6'h23, 5'd0, 5'd7, 16'd0);
        sw7    = i_op(6'h2b, 5'd0, 5'd7, 16'd4);
        addu0  = r_op(6'h21, 5'd1, 5'd2, 5'd0);
        subu4  = r_op(6'h23, 5'd0, 5'd0, 5'd4);
        mult12 = r_op(6'h18, 5'd1, 5'd2, 5'd0);
        mfhi3  = r_op(6'h10, 5'd0, 5'd0, 5'd3);
        div56  = r_op(6'h1a, 5'd5, 5'd6, 5'd0);

        rst_n      = 1'b0;
        hz.instr_d = mfhi3;
        hz.hold    = 1'b0;
        expect_out("reset_state", ev(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check_out();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // lw -> dependent addu: one stall, then both E operands from W
        cycle(lw1,   0, ev(0, 0, 0, 0, 0, 0, 0), "lw_issue");
        cycle(addu2, 0, ev(1, 0, 0, 0, 0, 0, 0), "lw_use_stall");
        cycle(addu2, 0, ev(0, 0, 0, 0, 0, 0, 0), "lw_use_release");
        cycle(NOP,   0, ev(0, 0, 0, 3, 3, 0, 0), "lw_use_fwd_e_w");
        cycle(NOP,   0, ev(0, 0, 0, 0, 0, 0, 0), "flush_a1");
        cycle(NOP,   0, ev(0, 0, 0, 0, 0, 0, 0), "flush_a2");

        // addu -> beq: one stall then D from M; jal -> jr forwards from E
        cycle(addu3, 0, ev(0, 0, 0, 0, 0, 0, 0), "alu_issue");
        cycle(beq3,  0, ev(1, 0, 0, 0, 0, 0, 0), "beq_stall");
        cycle(beq3,  0, ev(0, 2, 0, 0, 0, 0, 0), "beq_fwd_d_m");
        cycle(jal0,  0, ev(0, 0, 0, 3, 0, 0, 0), "beq_in_e_fwd_w");
        cycle(jr31,  0, ev(0, 1, 0, 0, 0, 0, 0), "jr_fwd_d_e");
        cycle(NOP,   0, ev(0, 0, 0, 2, 0, 0, 0), "jr_in_e_fwd_m");
        cycle(NOP,   0, ev(0, 0, 0, 0, 0, 0, 0), "flush_b");

        // lw -> sw with store data Tuse 2: no stall, data from W in M
        cycle(lw7,   0, ev(0, 0, 0, 0, 0, 0, 0), "lw7_issue");
        cycle(sw7,   0, ev(0, 0, 0, 0, 0, 0, 0), "sw_tuse2_no_stall");
        cycle(NOP,   0, ev(0, 0, 0, 0, 0, 0, 0), "sw_in_e");
        cycle(NOP,   0, ev(0, 0, 0, 0, 0, 1, 0), "sw_fwd_m_w");
        cycle(NOP,   0, ev(0, 0, 0, 0, 0, 0, 0), "flush_s");

        // $0 destination never hazards or forwards
        cycle(addu0, 0, ev(0, 0, 0, 0, 0, 0, 0), "dest0_issue");
        cycle(subu4, 0, ev(0, 0, 0, 0, 0, 0, 0), "dest0_no_stall");
        cycle(NOP,   0, ev(0, 0, 0, 0, 0, 0, 0), "dest0_no_fwd_e");
        cycle(NOP,   0, ev(0, 0, 0, 0, 0, 0, 0), "flush_c");

        // mult; mfhi: busy and stalled for MULT_LAT+1 cycles
        cycle(mult12, 0, ev(0, 0, 0, 0, 0, 0, 0), "mult_issue");
        for (int i = 0; i < 6; i++) begin
            cycle(mfhi3, 0, ev(1, 0, 0, 0, 0, 0, 1), $sformatf("mfhi_stall%0d", i));
        end
        cycle(mfhi3, 0, ev(0, 0, 0, 0, 0, 0, 0), "mfhi_release");
        cycle(div56, 0, ev(0, 0, 0, 0, 0, 0, 0), "div_issue");
        cycle(NOP,   0, ev(0, 0, 0, 0, 0, 0, 1), "div_in_e_busy");
        for (int i = 0; i < 10; i++) begin
            cycle(NOP, 0, ev(0, 0, 0, 0, 0, 0, 1), $sformatf("div_busy%0d", i));
        end
        cycle(NOP,   0, ev(0, 0, 0, 0, 0, 0, 0), "div_done");

        // hold freezes the shadow stages during a load-use stall
        cycle(lw1,   0, ev(0, 0, 0, 0, 0, 0, 0), "hold_lw_issue");
        for (int i = 0; i < 3; i++) begin
            cycle(addu2, 1, ev(1, 0, 0, 0, 0, 0, 0), $sformatf("hold_stall%0d", i));
        end
        cycle(addu2, 0, ev(1, 0, 0, 0, 0, 0, 0), "hold_released_stall");
        cycle(addu2, 0, ev(0, 0, 0, 0, 0, 0, 0), "hold_use_release");
        cycle(NOP,   0, ev(0, 0, 0, 3, 3, 0, 0), "hold_fwd_e_w");
        cycle(NOP,   0, ev(0, 0, 0, 0, 0, 0, 0), "flush_h1");
        cycle(NOP,   0, ev(0, 0, 0, 0, 0, 0, 0), "flush_h2");

        // reset asserted mid-cycle during an MD stall
        cycle(mult12, 0, ev(0, 0, 0, 0, 0, 0, 0), "rst_mult_issue");
        cycle(mfhi3,  0, ev(1, 0, 0, 0, 0, 0, 1), "rst_mfhi_stall0");
        cycle(mfhi3,  0, ev(1, 0, 0, 0, 0, 0, 1), "rst_mfhi_stall1");
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst_async_drop", ev(0, 0, 0, 0, 0, 0, 0));
        check_out();
        @(negedge clk);
        expect_out("rst_held", ev(0, 0, 0, 0, 0, 0, 0));
        check_out();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(mfhi3, 0, ev(0, 0, 0, 0, 0, 0, 0), "rst_counter_cleared");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It classifies the Decode-stage instruction and tracks destination register, class and remaining Tnew for E/M/W in its own shadow stage registers. From these it produces the D-stage stall/E-flush and the forwarding selects for D, E and M. A busy counter for a multi-cycle multiply/divide unit adds structural stalls on HI/LO access.

## Interface
- `REG_W`, 5: register index width
- `MULT_LAT`, 5: cycles a mult/multu occupies the MD unit after entering E
- `DIV_LAT`, 10: cycles a div/divu occupies the MD unit after entering E
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `instr_d` in 32: instruction currently in Decode
- `hold` in 1: external freeze (memory wait); freezes all shadow stage registers
- `stall` out 1: freeze F/D, insert bubble into E
- `fwd_rs_d`, `fwd_rt_d` out 2: D-stage operand source; 00 regfile, 01 E, 10 M, 11 W
- `fwd_rs_e`, `fwd_rt_e` out 2: E-stage operand source; 00 pipe reg, 10 M, 11 W
- `fwd_rt_m` out 1: M-stage store data from W
- `md_busy` out 1: MD unit occupied

## Operation
- Classes: NOP, CAL_R, CAL_I, LOAD, STORE, B, J, JAL, JR, JALR, MD (mult/multu/div/divu), MT (mthi/mtlo), MF (mfhi/mflo); unknown opcodes are NOP.
- Destination: CAL_R/JALR/MF rd; CAL_I/LOAD rt; JAL 31; all others 0. Destination 0 never hazards or forwards.
- Tuse: B/JR/JALR rs 0, B rt 0; CAL_R/CAL_I/LOAD/STORE/MD/MT rs 1, CAL_R/MD rt 1; STORE rt 2; unused sources are infinite.
- Tnew on entry to E: CAL_R/CAL_I/MF 1, LOAD 2, JAL/JALR 0. Decrements by 1 per stage advance, saturates at 0. W always 0.
- Shadow stages are {class, rs, rt, dest, tnew}.
  - Normal advance: D→E, E→M, M→W.
  - On `stall`, E receives a bubble (NOP, dest 0, tnew 0) while M and W still advance.
  - On `hold`, nothing advances; `hold` overrides `stall`.
- Data stall: for src in {rs, rt} with src≠0, stall if any X in {E, M} has dest_X==src and tnew_X > Tuse(src).
- MD stall: `md_busy` and the D class is MD, MT or MF.
- `stall` = data stall OR MD stall.
- Forwarding chooses the nearest matching stage with tnew==0.
  - D priority: E > M > W.
  - E priority: M > W.
  - M store data from W.
  - No match gives 00 / 0.
- MD counter (width ⌈log2(DIV_LAT+1)⌉):
  - Loads MULT_LAT or DIV_LAT on the cycle an MD op advances into E.
  - Otherwise decrements to 0, and keeps counting during `hold`.
  - A new MD op cannot enter E while the counter is nonzero (MD stall).
- `md_busy` = counter≠0 OR class_E==MD.

## Timing
- Decode, stall and forwarding outputs are combinational from `instr_d` and shadow registers; zero latency.
- Shadow registers and counter update on the rising `clk` edge.
- Reset (any time, mid-operation included):
  - All stages become bubbles and the counter becomes 0.
  - Outputs: `stall` 0, all fwd 0, `md_busy` 0.
- lw→dependent CAL_R stalls 1 cycle. lw→dependent beq stalls 2 cycles.
- CAL_R→dependent beq stalls 1 cycle, then forwards from M.
- mult in E at cycle t: `md_busy` is high from t through t+MULT_LAT. An mfhi in D is released at t+MULT_LAT+1.

## Structure
- Shared package `cpu_pkg`:
  - class enum
  - opcode/funct constants
  - Tuse/Tnew constants
  - fwd select encodings (FWD_RF, FWD_E, FWD_M, FWD_W)
  - shadow-stage struct
- Sub-module `instr_class`: combinational `instr_d` → class, rs, rt, dest, tuse_rs, tuse_rt, tnew. Reused by other pipeline blocks.
- `hazard_ctrl` holds only the shadow pipeline, MD counter, stall and forwarding logic.

## Test plan
- lw $1,0($0); addu $2,$1,$1 → `stall`=1 one cycle, then `fwd_rs_e`=`fwd_rt_e`=11 (W).
- addu $3,$4,$5; beq $3,$0 → `stall`=1 one cycle, then `fwd_rs_d`=10 (M); jal then jr $31 next → no stall, `fwd_rs_d`=01.
- addu $0,$1,$2; subu $4,$0,$0 → no stall, all fwd 00 (dest 0 ignored).
- mult $1,$2; mfhi $3 (MULT_LAT=5) → `md_busy` 6 cycles, `stall` until counter 0; div reloads 10.
- lw→dependent addu with `hold`=1 for 3 cycles during the stall → shadow state frozen, `stall` stays 1, resolves on the first unheld cycle.
- `rst_n` low during an MD stall → `stall`/`md_busy` drop immediately, all fwd 00, counter 0.
